// File: rtl/i2c_inject_pkg.sv
// i2c_inject_pkg: shared definitions for the I2C byte transmitter.
//   state_t      : FSM state encoding (also exported on the debug port)
//   Q0..Q3       : quarter-phase indices within a bit
//   RSP_W        : response word width, {byte[8:1], nack[0]}
//   pins()       : open-drain drive {scl_oe, sda_oe} for a state/quarter/bit
package i2c_inject_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BIT    = 3'd2,
        S_ACK    = 3'd3,
        S_HOLD   = 3'd4,
        S_RSTART = 3'd5,
        S_STOP   = 3'd6,
        S_FREE   = 3'd7
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int RSP_W = 9;

    // Returns {scl_oe, sda_oe}; 1 = pull the line low.
    // In BIT/ACK, SCL is low for q0/q1 and released for q2/q3.
    function automatic logic [1:0] pins(input state_t s, input logic [1:0] q, input logic b);
        logic [1:0] p;
        p = 2'b00;
        case (s)
            S_START:  p = 2'b01;
            S_BIT:    p = {~q[1], ~b};
            S_ACK:    p = {~q[1], 1'b0};
            S_HOLD:   p = 2'b10;
            S_RSTART: p = {~q[0], 1'b0};
            S_STOP:   p = {~q[1], (q != Q3)};
            default:  p = 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/i2c_inject_if.sv
// i2c_inject_if: command/response handshake plus open-drain pin signals.
//   Handshake: a command transfers on a cycle where cmd_valid && cmd_ready are
//   both 1; the command fields must be stable while cmd_valid is 1. rsp_valid is
//   a one-cycle pulse with no back-pressure; rsp_data holds until the next pulse.
//   master : the transmitter (drives cmd_ready, rsp_*, busy, *_oe)
//   slave  : the command source / pad side (drives cmd_*, scl_in, sda_in)
interface i2c_inject_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic [7:0] cmd_byte;
    logic       rsp_valid;
    logic [8:0] rsp_data;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        input  cmd_valid, cmd_start, cmd_stop, cmd_byte, scl_in, sda_in,
        output cmd_ready, rsp_valid, rsp_data, busy, scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd_start, cmd_stop, cmd_byte, scl_in, sda_in,
        input  cmd_ready, rsp_valid, rsp_data, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_inject_qtick.sv
// i2c_inject_qtick: quarter-bit timebase.
//   clk, reset : clock, asynchronous active-high reset
//   restart    : reload the count so the next tick is exactly CLK_DIV cycles away
//   hold       : keep the count at 0 (clock stretching), no tick while high
//   tick       : one-cycle pulse on the last cycle of each quarter
module i2c_inject_qtick #(
    parameter int CLK_DIV = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic hold,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !hold && !restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || hold || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_inject.sv
// i2c_inject: I2C byte transmitter (bus initiator). Takes {start,stop,byte}
// commands, drives SCL/SDA open-drain, samples the target ACK and returns
// {byte, nack} as a 9-bit response.
//   clk, reset : clock, asynchronous active-high reset (releases pins at once)
//   bus        : i2c_inject_if.master (command, response, busy, pins)
//   dbg_state  : current FSM state
// Optional feature: define I2C_STRETCH_EN to let the target stretch SCL; when
// undefined scl_in is ignored and timing is purely CLK_DIV based.
module i2c_inject
    import i2c_inject_pkg::*;
#(
    parameter int CLK_DIV = 60,
    parameter int FREE_Q  = 4
) (
    input  logic         clk,
    input  logic         reset,
    i2c_inject_if.master bus,
    output state_t       dbg_state
);
    localparam int FW = (FREE_Q > 1) ? $clog2(FREE_Q) : 1;
    localparam logic [FW-1:0] FREE_LAST = FW'(FREE_Q - 1);

    state_t          state;
    logic [1:0]      q;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      byte_r;
    logic            stop_r;
    logic            ack_smp;
    logic [FW-1:0]   free_cnt;
    logic            scl_oe_r, sda_oe_r, ready_r, rsp_valid_r, busy_r;
    logic [RSP_W-1:0] rsp_data_r;
    logic            accept, tick, stretch_hold;
    logic [1:0]      q_nxt;

    assign accept = bus.cmd_valid && ready_r;
    assign q_nxt  = q + 2'd1;

`ifdef I2C_STRETCH_EN
    // Freeze the quarter count while the target holds SCL low in the quarter
    // where we have just released SCL (q2 of BIT/ACK, q1 of RSTART).
    assign stretch_hold = !bus.scl_in &&
                          ((((state == S_BIT) || (state == S_ACK)) && (q == Q2)) ||
                           ((state == S_RSTART) && (q == Q1)));
`else
    logic unused_scl;
    assign unused_scl   = bus.scl_in;
    assign stretch_hold = 1'b0;
`endif

    i2c_inject_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .hold    (stretch_hold),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            q           <= Q0;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_r      <= '0;
            stop_r      <= 1'b0;
            ack_smp     <= 1'b0;
            free_cnt    <= '0;
            scl_oe_r    <= 1'b0;
            sda_oe_r    <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_r <= 1'b1;
                    // A command from IDLE always begins with START, whatever cmd_start says.
                    if (accept) begin
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        byte_r   <= bus.cmd_byte;
                        shreg    <= bus.cmd_byte;
                        stop_r   <= bus.cmd_stop;
                        state    <= S_START;
                        q        <= Q0;
                        {scl_oe_r, sda_oe_r} <= pins(S_START, Q0, 1'b0);
                    end
                end
                S_START: if (tick) begin
                    if (q == Q1) begin
                        state   <= S_BIT;
                        q       <= Q0;
                        bit_cnt <= '0;
                        {scl_oe_r, sda_oe_r} <= pins(S_BIT, Q0, shreg[7]);
                    end else begin
                        q <= q_nxt;
                    end
                end
                S_BIT: if (tick) begin
                    if (q != Q3) begin
                        q <= q_nxt;
                        {scl_oe_r, sda_oe_r} <= pins(S_BIT, q_nxt, shreg[7]);
                    end else if (bit_cnt == 3'd7) begin
                        state <= S_ACK;
                        q     <= Q0;
                        {scl_oe_r, sda_oe_r} <= pins(S_ACK, Q0, 1'b0);
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        q       <= Q0;
                        {scl_oe_r, sda_oe_r} <= pins(S_BIT, Q0, shreg[6]);
                    end
                end
                S_ACK: if (tick) begin
                    // SDA is sampled on the q2->q3 boundary, mid SCL-high.
                    if (q == Q2) ack_smp <= bus.sda_in;
                    if (q != Q3) begin
                        q <= q_nxt;
                        {scl_oe_r, sda_oe_r} <= pins(S_ACK, q_nxt, 1'b0);
                    end else begin
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= {byte_r, ack_smp};
                        q           <= Q0;
                        // NACK does not abort; only cmd_stop decides.
                        if (stop_r) begin
                            state <= S_STOP;
                            {scl_oe_r, sda_oe_r} <= pins(S_STOP, Q0, 1'b0);
                        end else begin
                            state   <= S_HOLD;
                            ready_r <= 1'b1;
                            {scl_oe_r, sda_oe_r} <= pins(S_HOLD, Q0, 1'b0);
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        ready_r <= 1'b0;
                        byte_r  <= bus.cmd_byte;
                        shreg   <= bus.cmd_byte;
                        stop_r  <= bus.cmd_stop;
                        q       <= Q0;
                        if (bus.cmd_start) begin
                            state <= S_RSTART;
                            {scl_oe_r, sda_oe_r} <= pins(S_RSTART, Q0, 1'b0);
                        end else begin
                            state   <= S_BIT;
                            bit_cnt <= '0;
                            {scl_oe_r, sda_oe_r} <= pins(S_BIT, Q0, bus.cmd_byte[7]);
                        end
                    end
                end
                S_RSTART: if (tick) begin
                    if (q == Q1) begin
                        state <= S_START;
                        q     <= Q0;
                        {scl_oe_r, sda_oe_r} <= pins(S_START, Q0, 1'b0);
                    end else begin
                        q <= q_nxt;
                        {scl_oe_r, sda_oe_r} <= pins(S_RSTART, q_nxt, 1'b0);
                    end
                end
                S_STOP: if (tick) begin
                    if (q == Q3) begin
                        state    <= S_FREE;
                        q        <= Q0;
                        busy_r   <= 1'b0;
                        free_cnt <= '0;
                        {scl_oe_r, sda_oe_r} <= pins(S_FREE, Q0, 1'b0);
                    end else begin
                        q <= q_nxt;
                        {scl_oe_r, sda_oe_r} <= pins(S_STOP, q_nxt, 1'b0);
                    end
                end
                S_FREE: if (tick) begin
                    if (free_cnt == FREE_LAST) begin
                        state   <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        free_cnt <= free_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;
    assign bus.scl_oe    = scl_oe_r;
    assign bus.sda_oe    = sda_oe_r;
    assign dbg_state     = state;
endmodule
